max_scan_ctrl: RTL and testbench



---
 rtl/max_scan_ctrl.sv | 93 +++++++++
 tb/tb_max_scan_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/max_scan_ctrl.sv
// max_scan_ctrl: finds the maximum of a frame of unsigned words, one word per
// cycle, using a single shared greater-than comparator. The first occurrence of
// the maximum is reported because ties never replace the stored value.
module max_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_idx,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;

    // Frame controller: state, counters, running maximum and the registered
    // handshake flags all move together so no input reaches an output directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            len_q     <= '0;
            out_max   <= '0;
            out_idx   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        out_max <= '0;
                        out_idx <= '0;
                        busy    <= 1'b1;
                        if (len != '0) begin
                            len_q    <= len;
                            cnt      <= '0;
                            in_ready <= 1'b1;
                            state    <= RUN;
                        end else begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (cnt == '0 || in_data > out_max) begin
                            out_max <= in_data;
                            out_idx <= cnt;
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == len_q - CNT_W'(1)) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_scan_ctrl.sv
// tb_max_scan_ctrl: directed and randomized frames checked against a simple
// "max of the list, first index holding it" reference model.
module tb_max_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_max;
    logic [7:0]  out_idx;
    logic        out_ready;
    logic        busy;

    int total;
    int bad;

    logic [15:0] words[$];
    logic [15:0] expMax;
    logic [7:0]  expIdx;

    max_scan_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_max(out_max),
        .out_idx(out_idx),
        .out_ready(out_ready),
        .busy(busy)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: the largest word in the list and the first position holding it
    function automatic void refModel();
        bit found;
        expMax = '0;
        expIdx = '0;
        found  = 1'b0;
        for (int i = 0; i < words.size(); i++)
            if (words[i] > expMax) expMax = words[i];
        for (int i = 0; i < words.size(); i++)
            if (!found && words[i] == expMax) begin
                expIdx = 8'(i);
                found  = 1'b1;
            end
    endfunction

    // Start a frame of words[], feed it with random bubbles, check the result
    task automatic applyStimulus(input int bubblePct);
        int n;
        int i;
        int cyc;
        int guard;
        logic acc;
        n = words.size();
        refModel();
        start = 1'b1;
        len   = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        checkOutput("start_in_ready", in_ready, (n != 0));
        checkOutput("start_busy", busy, 1);
        i = 0;
        guard = 0;
        while (i < n && guard < 5000) begin
            in_valid = ($urandom_range(99) >= bubblePct);
            in_data  = in_valid ? words[i] : 16'($urandom);
            len      = 8'($urandom);
            acc      = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            guard++;
            if (acc) i++;
            if (i < n) checkOutput("early_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        checkOutput("words_accepted", i, n);
        if (bubblePct == 0) checkOutput("latency", cyc, n + 1);
        checkOutput("out_valid", out_valid, 1);
        checkOutput("out_max", out_max, expMax);
        checkOutput("out_idx", out_idx, expIdx);
        checkOutput("done_in_ready", in_ready, 0);
        checkOutput("done_busy", busy, 1);
    endtask

    // Hold the result under backpressure, optionally poke start, then take it
    task automatic finishResult(input int holdCycles, input bit pulseStart);
        out_ready = 1'b0;
        for (int k = 0; k < holdCycles; k++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_max", out_max, expMax);
            checkOutput("hold_idx", out_idx, expIdx);
            checkOutput("hold_in_ready", in_ready, 0);
        end
        if (pulseStart) begin
            start = 1'b1;
            len   = 8'd3;
            @(posedge clk); #1;
            start = 1'b0;
            checkOutput("ignored_start_valid", out_valid, 1);
            checkOutput("ignored_start_max", out_max, expMax);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("idle_valid", out_valid, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_max_held", out_max, expMax);
        checkOutput("idle_idx_held", out_idx, expIdx);
        @(posedge clk); #1;
        checkOutput("stay_idle_busy", busy, 0);
        checkOutput("stay_idle_in_ready", in_ready, 0);
    endtask

    // Directed sequence followed by randomized frames
    initial begin
        int n;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_max", out_max, 0);
        checkOutput("rst_out_idx", out_idx, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        words = '{16'd10, 16'd20};
        applyStimulus(0);
        finishResult(0, 1'b0);

        words = '{16'd40, 16'd30};
        applyStimulus(0);
        finishResult(0, 1'b0);

        words = '{16'd5, 16'd7, 16'd7, 16'hFFFF, 16'hFFFF, 16'd3};
        applyStimulus(0);
        finishResult(5, 1'b0);

        words = '{16'd0, 16'd0, 16'd0};
        applyStimulus(0);
        finishResult(0, 1'b1);

        words = {};
        applyStimulus(0);
        finishResult(2, 1'b0);

        // Reset in the middle of a 4-word frame
        words = '{16'd100, 16'd200, 16'd300, 16'd50};
        start = 1'b1;
        len   = 8'd4;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = words[0];
        @(posedge clk); #1;
        in_data  = words[1];
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("pre_rst_max", out_max, 16'd200);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_max", out_max, 0);
        checkOutput("mid_rst_idx", out_idx, 0);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_in_ready", in_ready, 0);
        checkOutput("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_busy", busy, 0);

        words = '{16'd1, 16'd9, 16'd4};
        applyStimulus(0);
        finishResult(0, 1'b0);

        words = '{16'd1, 16'd9, 16'd4};
        applyStimulus(50);
        finishResult(0, 1'b0);

        // Randomized frames, some drawn from a tiny range to force ties
        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(1, 20);
            words = {};
            for (int j = 0; j < n; j++)
                words.push_back((f % 2 == 0) ? 16'($urandom_range(0, 5)) : 16'($urandom));
            applyStimulus(30);
            finishResult($urandom_range(0, 3), f == 3);
        end

        // Largest frame
        words = {};
        for (int j = 0; j < 255; j++) words.push_back(16'($urandom_range(0, 1000)));
        applyStimulus(0);
        finishResult(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
